// File: rtl/shift_pkg.sv
// Shared types for the serial shift unit: operation encodings and FSM states.
package shift_pkg;

   typedef enum logic [2:0] {
      LSL  = 3'b000,
      LSR  = 3'b001,
      ASR  = 3'b010,
      ROL  = 3'b011,
      ROR  = 3'b100,
      HOLD = 3'b101
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   // Every encoding above ROR collapses to HOLD so the step logic sees one value.
   function automatic mode_t decode_mode(input logic [2:0] m);
      if (m > 3'b100) return HOLD;
      else            return mode_t'(m);
   endfunction

endpackage

// File: rtl/shift_step.sv
// One-position combinational shift/rotate step used by shift_unit each SHIFT cycle.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] y,
   input  mode_t            mode,
   input  logic             sin,
   output logic [WIDTH-1:0] y_nxt,
   output logic             carry_nxt
);

   always_comb begin
      y_nxt     = y;
      carry_nxt = 1'b0;
      case (mode)
         LSL: begin
            y_nxt     = {y[WIDTH-2:0], sin};
            carry_nxt = y[WIDTH-1];
         end
         LSR: begin
            y_nxt     = {sin, y[WIDTH-1:1]};
            carry_nxt = y[0];
         end
         ASR: begin
            y_nxt     = {y[WIDTH-1], y[WIDTH-1:1]};
            carry_nxt = y[0];
         end
         ROL: begin
            y_nxt     = {y[WIDTH-2:0], y[WIDTH-1]};
            carry_nxt = y[WIDTH-1];
         end
         ROR: begin
            y_nxt     = {y[0], y[WIDTH-1:1]};
            carry_nxt = y[0];
         end
         default: begin
            y_nxt     = y;
            carry_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle serial shifter: loads an operand, steps it one position per cycle
// for amt cycles, then pulses done with the result held in y/carry.
module shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] a,
   input  logic             sin,
   output logic [WIDTH-1:0] y,
   output logic             carry,
   output logic             busy,
   output logic             done
);

   localparam logic [AMT_W:0] AMT_MAX = (AMT_W + 1)'(WIDTH - 1);

   state_t           state, state_nxt;
   mode_t            mode_q;
   logic [AMT_W-1:0] cnt;
   logic [AMT_W-1:0] amt_sat;
   logic [WIDTH-1:0] step_y;
   logic             step_carry;

   // Only reachable for non-power-of-two widths; clamps to the largest legal count.
   always_comb begin
      amt_sat = amt;
      if ({1'b0, amt} > AMT_MAX) amt_sat = AMT_MAX[AMT_W-1:0];
   end

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .y         (y),
      .mode      (mode_q),
      .sin       (sin),
      .y_nxt     (step_y),
      .carry_nxt (step_carry)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = (amt_sat != '0) ? SHIFT : DONE;
         end
         SHIFT: begin
            if (cnt == AMT_W'(1)) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // busy/done are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         mode_q <= HOLD;
         cnt    <= '0;
         y      <= '0;
         carry  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         done  <= (state_nxt == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  y      <= a;
                  carry  <= 1'b0;
                  cnt    <= amt_sat;
                  mode_q <= decode_mode(mode);
               end
            end
            SHIFT: begin
               y     <= step_y;
               carry <= step_carry;
               cnt   <= cnt - AMT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit (WIDTH=8): directed operations push expected
// results and completion cycles; a monitor checks them whenever done pulses.
module tb_shift_unit;

   localparam int W  = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    mode = 3'b000;
   logic [AW-1:0] amt = '0;
   logic [W-1:0]  a = '0;
   logic          sin = 1'b0;
   logic [W-1:0]  y;
   logic          carry;
   logic          busy;
   logic          done;

   typedef struct {
      logic [W-1:0] y;
      logic         c;
      int           cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic prev_done = 1'b0;

   shift_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mode  (mode),
      .amt   (amt),
      .a     (a),
      .sin   (sin),
      .y     (y),
      .carry (carry),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops one expectation per done pulse and checks protocol rules.
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_done) begin
            checks++;
            if (done) begin
               errors++;
               $display("FAIL double_done cyc=%0d got done=1 need 0", cyc);
            end
            checks++;
            if (busy) begin
               errors++;
               $display("FAIL busy_after_done cyc=%0d got busy=1 need 0", cyc);
            end
         end
         if (done && !prev_done) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL spurious_done cyc=%0d no operation outstanding", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (y !== e.y) begin
                  errors++;
                  $display("FAIL result_y cyc=%0d got %b need %b", cyc, y, e.y);
               end
               checks++;
               if (carry !== e.c) begin
                  errors++;
                  $display("FAIL result_carry cyc=%0d got %b need %b", cyc, carry, e.c);
               end
               checks++;
               if (cyc != e.cyc) begin
                  errors++;
                  $display("FAIL done_latency got cyc %0d need cyc %0d", cyc, e.cyc);
               end
            end
         end
         prev_done <= done;
      end else begin
         prev_done <= 1'b0;
      end
   end

   task automatic issue(input logic [2:0] m, input logic [AW-1:0] n, input logic [W-1:0] av,
                        input logic s, input logic [W-1:0] ey, input logic ec);
      @(negedge clk);
      mode = m; amt = n; a = av; sin = s; start = 1'b1;
      @(posedge clk);
      #1;
      q.push_back('{y: ey, c: ec, cyc: cyc + int'(n)});
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while ((q.size() != 0 || busy) && k < 80) begin
         @(posedge clk);
         k++;
      end
      @(posedge clk);
      checks++;
      if (q.size() != 0 || busy) begin
         errors++;
         $display("FAIL timeout_%s got pending=%0d busy=%b need 0 0", tag, q.size(), busy);
         q.delete();
      end
   endtask

   task automatic check_bit(input string tag, input logic got, input logic need);
      checks++;
      if (got !== need) begin
         errors++;
         $display("FAIL %s got %b need %b", tag, got, need);
      end
   endtask

   initial begin
      int k0;
      #2;
      check_bit("reset_y_zero", (y == '0), 1'b1);
      check_bit("reset_carry", carry, 1'b0);
      check_bit("reset_busy", busy, 1'b0);
      check_bit("reset_done", done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(3'b000, 3'd3, 8'b10101010, 1'b0, 8'b01010000, 1'b1);  // LSL
      wait_idle("lsl");
      issue(3'b100, 3'd2, 8'b11001101, 1'b0, 8'b01110011, 1'b0);  // ROR
      wait_idle("ror");
      issue(3'b010, 3'd7, 8'b10000000, 1'b0, 8'b11111111, 1'b0);  // ASR
      wait_idle("asr");
      issue(3'b001, 3'd4, 8'b00000000, 1'b1, 8'b11110000, 1'b0);  // LSR, sin=1
      wait_idle("lsr");
      issue(3'b001, 3'd0, 8'b10110001, 1'b1, 8'b10110001, 1'b0);  // amt=0
      wait_idle("amt0");
      issue(3'b011, 3'd1, 8'b10000001, 1'b0, 8'b00000011, 1'b1);  // ROL
      wait_idle("rol");
      issue(3'b111, 3'd3, 8'b01011010, 1'b1, 8'b01011010, 1'b0);  // HOLD
      wait_idle("hold");
      issue(3'b010, 3'd1, 8'b01000000, 1'b0, 8'b00100000, 1'b0);  // ASR positive
      wait_idle("asr_pos");

      // start pulse during SHIFT must be ignored
      issue(3'b000, 3'd5, 8'b00001111, 1'b0, 8'b11100000, 1'b1);
      @(negedge clk); @(negedge clk);
      mode = 3'b011; amt = 3'd1; a = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("ignore_start");
      check_bit("hold_y_idle", (y == 8'b11100000), 1'b1);

      // asynchronous reset in the middle of a shift (cnt=2)
      issue(3'b000, 3'd5, 8'hFF, 1'b0, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      q.delete();
      check_bit("midreset_y_zero", (y == '0), 1'b1);
      check_bit("midreset_carry", carry, 1'b0);
      check_bit("midreset_busy", busy, 1'b0);
      check_bit("midreset_done", done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(3'b100, 3'd7, 8'b00000001, 1'b0, 8'b00000010, 1'b0);  // ROR after reset
      wait_idle("after_reset");

      // start held high: accepted only in IDLE, period amt+2
      @(negedge clk);
      mode = 3'b000; amt = 3'd2; a = 8'b00000011; sin = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      k0 = cyc;
      for (int i = 0; i < 3; i++) q.push_back('{y: 8'b00001111, c: 1'b0, cyc: k0 + 2 + 4 * i});
      repeat (8) @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle("back_to_back");

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL leftover_ops got %0d need 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits; legal range WIDTH >= 2.
REQ-002 SHALL have derived parameter AMT_W, default $clog2(WIDTH), which is the shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 mode  input  3  operation, sampled with start: 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101-111 HOLD.
REQ-007 amt  input  AMT_W  shift count 0..WIDTH-1, sampled with start.
REQ-008 a  input  WIDTH  parallel operand, sampled with start.
REQ-009 sin  input  1  serial fill bit for LSL/LSR, sampled on every shift cycle (not latched).
REQ-010 y  output  WIDTH  working/result register.
REQ-011 carry  output  1  last bit shifted or rotated out.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle result-valid pulse.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 IDLE with start=1: y<=a, carry<=0, cnt<=amt, mode latched; next state SHIFT if amt!=0, else DONE.
REQ-016 Each SHIFT cycle: one-position step per latched mode; cnt<=cnt-1; next state DONE when cnt==1, else stay in SHIFT.
REQ-017 LSL: y<={y[W-2:0],sin}, carry<=y[W-1].
REQ-018 LSR: y<={sin,y[W-1:1]}, carry<=y[0].
REQ-019 ASR: y<={y[W-1],y[W-1:1]}, carry<=y[0].
REQ-020 ROL: y<={y[W-2:0],y[W-1]}, carry<=y[W-1].
REQ-021 ROR: y<={y[0],y[W-1:1]}, carry<=y[0].
REQ-022 HOLD: y unchanged, carry<=0; cycle count identical to other modes.
REQ-023 DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-024 done SHALL rise on the edge amt cycles after the start-sampling edge, and on that same edge when amt=0.
REQ-025 y and carry SHALL hold the result from DONE through IDLE until the next accepted start.
REQ-026 start while busy=1 SHALL be ignored, with no effect on state, y or carry.
REQ-027 start asserted during DONE SHALL be ignored; start is accepted only in the following IDLE cycle.
REQ-028 amt>=WIDTH is unreachable by width when WIDTH is a power of two; otherwise amt SHALL be saturated to WIDTH-1 at sampling.
REQ-029 done, busy, y and carry SHALL be registered outputs, with no combinational path from inputs.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, y=0, carry=0, cnt=0, busy=0, done=0, including mid-SHIFT.
REQ-031 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled.

Structure
REQ-032 Package shift_pkg SHALL hold the mode_t enum (LSL, LSR, ASR, ROL, ROR, HOLD encodings) and the state_t enum (IDLE, SHIFT, DONE).
REQ-033 A single-position combinational step SHALL be a sub-module shift_step (inputs: y, mode, sin; outputs: next y, next carry), instantiated once.
REQ-034 The FSM, counter and registers SHALL reside in shift_unit.

Verification (WIDTH=8)
REQ-035 LSL, a=10101010, amt=3, sin=0 -> done 3 cycles after start, y=01010000, carry=1, busy low the cycle after done.
REQ-036 ROR, a=11001101, amt=2 -> y=01110011, carry=0; ASR, a=10000000, amt=7 -> y=11111111, carry=0.
REQ-037 LSR, a=00000000, amt=4, sin=1 held -> y=11110000, carry=0; then amt=0, a=10110001 -> done on start edge+0, y=10110001, carry=0.
REQ-038 start pulsed again during SHIFT of an amt=5 LSL, with different a -> ignored, original result produced, done exactly once.
REQ-039 rst_n low mid-SHIFT (cnt=2) -> y=0, carry=0, busy=0, done=0 immediately without a clock; a new start after release runs normally.
REQ-040 Back-to-back: start held high continuously -> accepted in IDLE only, one done per operation, never two consecutive done cycles.
